uart_rx: RTL and testbench

Standalone UART receiver: deserialises an 8N1 asynchronous serial line into bytes and presents them on a valid/ready handshake. It sits next to the `uart` block's transmit side, driven from an external `rx` pin or looped back from a `tx` output. It accepts the same byte handshake the transmitter consumes, with `rx_data`, `rx_valid` and `rx_ready` playing the output role. Framing and overrun errors are reported as single-cycle pulses.

---
 rtl/uart_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 serial line to bytes on a valid/ready handshake.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic          sync1_q, rxs_q, rxs_prev_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          fe_q, ov_q, ov_d, pe_q;
    logic          deliver_s, frame_bad_s, par_bad_s;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
`endif

    // Input synchroniser and previous-sample register for start-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rx;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Frame FSM state, baud counter, bit counter and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Captured parity bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // Next-state logic; every sample happens when the baud counter reaches zero
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        deliver_s   = 1'b0;
        frame_bad_s = 1'b0;
        par_bad_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    cnt_d   = HALF_M1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (rxs_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = FULL_M1;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    par_d   = rxs_q;
                    cnt_d   = FULL_M1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!rxs_q) begin
                    // Framing error wins over parity; wait out a held-low line
                    frame_bad_s = 1'b1;
                    state_d     = S_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                end else if (par_q != even_parity(shift_q)) begin
                    par_bad_s = 1'b1;
                    state_d   = S_IDLE;
`endif
                end else begin
                    deliver_s = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register: a consumer transfer in the delivery cycle frees the slot
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ov_d    = 1'b0;
        if (deliver_s) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Registered byte output and single-cycle error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= frame_bad_s;
            ov_q    <= ov_d;
            pe_q    <= par_bad_s;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = fe_q;
    assign overrun_err = ov_q;
    assign parity_err  = pe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus a randomized run
// checked against a byte-level model of the holding register and error counts.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = H + 10 * CPB + 3;
`else
    localparam int LAT = H + 9 * CPB + 3;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun_err, parity_err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun_err(overrun_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: rising edges of rx_valid, high cycles of each error output
    logic prev_v = 1'b0;
    int rise_cnt = 0, rise_cyc = 0;
    int fe_cnt = 0, fe_cyc = 0, ov_cnt = 0, ov_cyc = 0, pe_cnt = 0, pe_cyc = 0;
    always @(negedge clk) begin
        prev_v <= rx_valid;
        if (rx_valid && !prev_v) begin rise_cnt <= rise_cnt + 1; rise_cyc <= cyc; end
        if (frame_err)   begin fe_cnt <= fe_cnt + 1; fe_cyc <= cyc; end
        if (overrun_err) begin ov_cnt <= ov_cnt + 1; ov_cyc <= cyc; end
        if (parity_err)  begin pe_cnt <= pe_cnt + 1; pe_cyc <= cyc; end
    end

    int total = 0, bad = 0;
    int t0 = 0;
    int exp_rise = 0, exp_fe = 0, exp_ov = 0, exp_pe = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        @(negedge clk);
        rx = 1'b0;
        t0 = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`else
        if (par_flip) t0 = cyc - CPB;
`endif
        rx = stop_b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic consume();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // Model of a well-formed frame arriving with rx_ready low
    task automatic model_good(input logic [7:0] d);
        if (!exp_valid) begin
            exp_valid = 1'b1;
            exp_data  = d;
            exp_rise++;
        end else begin
            exp_ov++;
        end
    endtask

    logic [7:0] rd;
    logic       rstop, rcons, deliver_new;

    initial begin
        #20;
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_errs", {frame_err, overrun_err, parity_err}, 0);
        #5 reset = 1'b0;
        idle(4);

        // Single frame, consumer not ready
        send_frame(8'h95, 1'b1, 1'b0);
        model_good(8'h95);
        chk("lat_rise_cyc", rise_cyc, t0 + LAT);
        chk("f1_valid", rx_valid, 1);
        chk("f1_data", rx_data, 8'h95);
        repeat (10) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        exp_valid = 1'b0;
        chk("f1_clear", rx_valid, 0);

        // Overrun: second byte dropped
        idle(3);
        send_frame(8'h95, 1'b1, 1'b0);
        model_good(8'h95);
        idle(2);
        send_frame(8'h3C, 1'b1, 1'b0);
        model_good(8'h3C);
        chk("ovr_data", rx_data, 8'h95);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_cnt", ov_cnt, exp_ov);
        chk("ovr_cyc", ov_cyc, t0 + LAT);
        consume();
        exp_valid = 1'b0;

        // Framing error followed by a break
        idle(3);
        send_frame(8'hA5, 1'b0, 1'b0);
        exp_fe++;
        chk("fe_cnt", fe_cnt, exp_fe);
        chk("fe_cyc", fe_cyc, t0 + LAT);
        chk("fe_valid", rx_valid, 0);
        repeat (30 * CPB) @(negedge clk);
        chk("brk_fe_cnt", fe_cnt, exp_fe);
        chk("brk_rise", rise_cnt, exp_rise);
        idle(2 * CPB);
        send_frame(8'h01, 1'b1, 1'b0);
        model_good(8'h01);
        chk("post_brk_data", rx_data, 8'h01);
        chk("post_brk_rise", rise_cnt, exp_rise);
        consume();
        exp_valid = 1'b0;

        // Short glitch on the idle line
        idle(3);
        rx = 1'b0;
        repeat (H - 4) @(negedge clk);
        idle(12 * CPB);
        chk("gl_rise", rise_cnt, exp_rise);
        chk("gl_errs", fe_cnt + ov_cnt + pe_cnt, exp_fe + exp_ov + exp_pe);
        chk("gl_valid", rx_valid, 0);

        // Reset in mid-frame with a byte already held
        send_frame(8'h33, 1'b1, 1'b0);
        model_good(8'h33);
        chk("pre_rst_data", rx_data, 8'h33);
        idle(3);
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (5 * CPB + H + 1) @(negedge clk);
                reset = 1'b1;
                #1;
                chk("mid_rst_valid", rx_valid, 0);
                chk("mid_rst_data", rx_data, 8'h00);
                chk("mid_rst_errs", {frame_err, overrun_err, parity_err}, 0);
                repeat (3) @(negedge clk);
                reset = 1'b0;
            end
        join
        exp_valid = 1'b0;
        idle(CPB);
        chk("post_rst_quiet", rx_valid, 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        model_good(8'h5A);
        chk("post_rst_data", rx_data, 8'h5A);
        chk("post_rst_rise_cyc", rise_cyc, t0 + LAT);

`ifdef UART_RX_PARITY_EN
        consume();
        exp_valid = 1'b0;
        idle(3);
        send_frame(8'h95, 1'b1, 1'b1);
        exp_pe++;
        chk("pe_cnt", pe_cnt, exp_pe);
        chk("pe_cyc", pe_cyc, t0 + LAT);
        chk("pe_valid", rx_valid, 0);
        idle(3);
        send_frame(8'h95, 1'b1, 1'b0);
        model_good(8'h95);
        chk("par_ok_data", rx_data, 8'h95);
        chk("par_ok_valid", rx_valid, 1);
`endif

        // Randomized frames against the byte-level model
        for (int n = 0; n < 20; n++) begin
            rd    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            rcons = 1'($urandom_range(0, 1));
            if (rcons) begin
                consume();
                exp_valid = 1'b0;
                chk("rnd_consume", rx_valid, 0);
            end
            idle(2);
            deliver_new = rstop && !exp_valid;
            send_frame(rd, rstop, 1'b0);
            if (rstop) model_good(rd);
            else exp_fe++;
            chk("rnd_valid", rx_valid, exp_valid);
            chk("rnd_data", rx_data, exp_data);
            chk("rnd_fe", fe_cnt, exp_fe);
            chk("rnd_ov", ov_cnt, exp_ov);
            if (deliver_new) chk("rnd_lat", rise_cyc, t0 + LAT);
        end

        idle(4);
        chk("end_rise", rise_cnt, exp_rise);
        chk("end_pe", pe_cnt, exp_pe);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
